// File: rtl/exc_commit_if.sv
// Commit-stage handshake and CSR/pipeline side-band bundle for exc_commit_ctrl.
// master = requester/pipeline side, slave = the commit controller.
interface exc_commit_if;
    logic        ex_valid;
    logic [4:0]  ex_flags;
    logic        ex_ertn;
    logic [31:0] ex_pc;
    logic [31:0] ex_vaddr;
    logic        has_int;
    logic [31:0] ex_entry;
    logic [31:0] ertn_pc;
    logic        flush_ack;
    logic        ex_ready;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr;
    logic        ertn_flush;
    logic        flush_req;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output ex_valid, ex_flags, ex_ertn, ex_pc, ex_vaddr,
               has_int, ex_entry, ertn_pc, flush_ack,
        input  ex_ready, wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr,
               ertn_flush, flush_req, redirect_valid, redirect_pc
    );

    modport slave (
        input  ex_valid, ex_flags, ex_ertn, ex_pc, ex_vaddr,
               has_int, ex_entry, ertn_pc, flush_ack,
        output ex_ready, wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr,
               ertn_flush, flush_req, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/exc_commit_ctrl.sv
// Exception / ertn commit controller: accepts one WB instruction, commits the
// highest-priority event to the CSR file, drains the pipeline, then redirects
// fetch. Instructions with no event retire without leaving IDLE.
module exc_commit_ctrl (
    input  logic         clk,
    input  logic         rst,
    exc_commit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, COMMIT, DRAIN, REDIR} state_t;

    localparam logic KIND_EXC  = 1'b0;
    localparam logic KIND_ERTN = 1'b1;

    state_t      state_q, state_d;
    logic        kind_q, kind_d;
    logic [5:0]  ecode_q, ecode_d;
    logic [8:0]  esubcode_q, esubcode_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] vaddr_q, vaddr_d;
    logic [15:0] drain_cnt_q, drain_cnt_d;
    logic        ex_ready_q, ex_ready_d;
    logic        wb_ex_q, wb_ex_d;
    logic        ertn_flush_q, ertn_flush_d;
    logic        flush_req_q, flush_req_d;
    logic        redirect_valid_q, redirect_valid_d;

    logic        exc_hit;
    logic [5:0]  exc_code;

    // Fixed-priority exception select: interrupt first, then flags low to high.
    always_comb begin
        exc_hit  = 1'b1;
        exc_code = 6'h00;
        if (bus.has_int)          exc_code = 6'h00;
        else if (bus.ex_flags[0]) exc_code = 6'h08;
        else if (bus.ex_flags[1]) exc_code = 6'h0D;
        else if (bus.ex_flags[2]) exc_code = 6'h0B;
        else if (bus.ex_flags[3]) exc_code = 6'h0C;
        else if (bus.ex_flags[4]) exc_code = 6'h09;
        else                      exc_hit  = 1'b0;
    end

    // Next state, captured event fields and next registered outputs.
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        ecode_d     = ecode_q;
        esubcode_d  = esubcode_q;
        pc_d        = pc_q;
        vaddr_d     = vaddr_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            IDLE: begin
                // ex_ready is high here, so ex_valid alone marks a transfer.
                if (bus.ex_valid) begin
                    if (exc_hit) begin
                        kind_d     = KIND_EXC;
                        ecode_d    = exc_code;
                        esubcode_d = 9'h000;
                        pc_d       = bus.ex_pc;
                        vaddr_d    = bus.ex_vaddr;
                        state_d    = COMMIT;
                    end else if (bus.ex_ertn) begin
                        kind_d  = KIND_ERTN;
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                drain_cnt_d = 16'h0000;
                state_d     = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt_q != 16'hFFFF) drain_cnt_d = drain_cnt_q + 16'd1;
                if (bus.flush_ack) state_d = REDIR;
            end
            REDIR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ex_ready_d       = (state_d == IDLE);
        wb_ex_d          = (state_d == COMMIT) && (kind_d == KIND_EXC);
        ertn_flush_d     = (state_d == COMMIT) && (kind_d == KIND_ERTN);
        flush_req_d      = (state_d == DRAIN);
        redirect_valid_d = (state_d == REDIR);
    end

    // State, captured fields and output pulses; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            kind_q           <= KIND_EXC;
            ecode_q          <= '0;
            esubcode_q       <= '0;
            pc_q             <= '0;
            vaddr_q          <= '0;
            drain_cnt_q      <= '0;
            ex_ready_q       <= 1'b1;
            wb_ex_q          <= 1'b0;
            ertn_flush_q     <= 1'b0;
            flush_req_q      <= 1'b0;
            redirect_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            kind_q           <= kind_d;
            ecode_q          <= ecode_d;
            esubcode_q       <= esubcode_d;
            pc_q             <= pc_d;
            vaddr_q          <= vaddr_d;
            drain_cnt_q      <= drain_cnt_d;
            ex_ready_q       <= ex_ready_d;
            wb_ex_q          <= wb_ex_d;
            ertn_flush_q     <= ertn_flush_d;
            flush_req_q      <= flush_req_d;
            redirect_valid_q <= redirect_valid_d;
        end
    end

    assign bus.ex_ready       = ex_ready_q;
    assign bus.wb_ex          = wb_ex_q;
    assign bus.ertn_flush     = ertn_flush_q;
    assign bus.flush_req      = flush_req_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.wb_ecode       = ecode_q;
    assign bus.wb_esubcode    = esubcode_q;
    assign bus.wb_pc          = pc_q;
    assign bus.wb_vaddr       = vaddr_q;
    // Target read live in REDIR so the CSR writes from COMMIT are visible.
    assign bus.redirect_pc    = (state_q != REDIR)     ? 32'h0 :
                                (kind_q == KIND_ERTN)  ? bus.ertn_pc : bus.ex_entry;

    // At most one of the four pulses is high in any cycle.
    a_pulse_excl: assert property (@(posedge clk) disable iff (rst)
        $onehot0({wb_ex_q, ertn_flush_q, flush_req_q, redirect_valid_q}));

    // The drain counter starts from zero on every DRAIN entry.
    a_drain_clr: assert property (@(posedge clk) disable iff (rst)
        (state_q == COMMIT) |=> (drain_cnt_q == 16'h0000));
endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Bench for exc_commit_ctrl: directed scenarios plus random transactions
// checked against a transaction-level model of event priority and timing.
module tb_exc_commit_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exc_commit_if bus();

    exc_commit_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_pulses(input string tag, input bit e_ex, input bit e_ertn,
                              input bit e_freq, input bit e_redir, input bit e_rdy);
        chk({tag, ".wb_ex"},          bus.wb_ex,          e_ex);
        chk({tag, ".ertn_flush"},     bus.ertn_flush,     e_ertn);
        chk({tag, ".flush_req"},      bus.flush_req,      e_freq);
        chk({tag, ".redirect_valid"}, bus.redirect_valid, e_redir);
        chk({tag, ".ex_ready"},       bus.ex_ready,       e_rdy);
    endtask

    // Reference: kind 0 = silent, 1 = exception, 2 = ertn.
    task automatic model_event(input logic [4:0] flags, input bit ertn, input bit irq,
                               output int kind, output logic [5:0] code);
        logic [5:0] tbl [5];
        tbl = '{6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};
        kind = 0;
        code = 6'h00;
        if (irq) begin
            kind = 1;
        end else begin
            for (int i = 4; i >= 0; i--)
                if (flags[i]) begin kind = 1; code = tbl[i]; end
            if (kind == 0 && ertn) kind = 2;
        end
    endtask

    // One transaction, entered and left at a negedge with the DUT in IDLE.
    task automatic run_txn(input string tag, input logic [4:0] flags, input bit ertn,
                           input bit irq, input logic [31:0] pc, input logic [31:0] vaddr,
                           input logic [31:0] entry, input logic [31:0] epc, input int ack_dly);
        int kind;
        logic [5:0] code;
        model_event(flags, ertn, irq, kind, code);
        chk({tag, ".idle_ready"}, bus.ex_ready, 1'b1);
        bus.ex_valid  = 1'b1;
        bus.ex_flags  = flags;
        bus.ex_ertn   = ertn;
        bus.has_int   = irq;
        bus.ex_pc     = pc;
        bus.ex_vaddr  = vaddr;
        bus.ex_entry  = entry;
        bus.ertn_pc   = epc;
        bus.flush_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (kind == 0) begin
            chk_pulses({tag, ".silent"}, 0, 0, 0, 0, 1);
            bus.ex_valid = 1'b0;
            return;
        end
        chk_pulses({tag, ".commit"}, kind == 1, kind == 2, 0, 0, 0);
        if (kind == 1) begin
            chk({tag, ".ecode"},    bus.wb_ecode,    code);
            chk({tag, ".esubcode"}, bus.wb_esubcode, 9'h0);
            chk({tag, ".wb_pc"},    bus.wb_pc,       pc);
            chk({tag, ".wb_vaddr"}, bus.wb_vaddr,    vaddr);
        end
        // Inputs outside IDLE must be ignored.
        bus.ex_valid  = 1'($urandom_range(0, 1));
        bus.has_int   = 1'($urandom_range(0, 1));
        bus.flush_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        for (int d = 0; d <= ack_dly; d++) begin
            chk_pulses($sformatf("%s.drain%0d", tag, d), 0, 0, 1, 0, 0);
            bus.ex_valid  = 1'($urandom_range(0, 1));
            bus.has_int   = 1'($urandom_range(0, 1));
            bus.flush_ack = (d == ack_dly);
            @(negedge clk);
        end
        chk_pulses({tag, ".redir"}, 0, 0, 0, 1, 0);
        chk({tag, ".redirect_pc"}, bus.redirect_pc, (kind == 1) ? entry : epc);
        bus.ex_valid  = 1'b0;
        bus.flush_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk_pulses({tag, ".back_idle"}, 0, 0, 0, 0, 1);
        bus.flush_ack = 1'b0;
    endtask

    initial begin
        logic [4:0] rf;
        int r;
        rst           = 1'b1;
        bus.ex_valid  = 1'b0;
        bus.ex_flags  = '0;
        bus.ex_ertn   = 1'b0;
        bus.ex_pc     = '0;
        bus.ex_vaddr  = '0;
        bus.has_int   = 1'b0;
        bus.ex_entry  = '0;
        bus.ertn_pc   = '0;
        bus.flush_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk_pulses("reset", 0, 0, 0, 0, 1);
        chk("reset.ecode",    bus.wb_ecode,    6'h0);
        chk("reset.esubcode", bus.wb_esubcode, 9'h0);
        chk("reset.wb_pc",    bus.wb_pc,       32'h0);
        chk("reset.wb_vaddr", bus.wb_vaddr,    32'h0);
        chk("reset.redirect_pc", bus.redirect_pc, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset.ex_ready", bus.ex_ready, 1'b1);

        // Directed scenarios.
        run_txn("sys",     5'b00100, 0, 0, 32'h1C000100, 32'h0, 32'h1C008000, 32'h0, 0);
        run_txn("pri_int", 5'b10011, 0, 1, 32'h1C000110, 32'h4, 32'h1C008000, 32'h0, 0);
        run_txn("pri_adef",5'b10011, 0, 0, 32'h1C000120, 32'h8, 32'h1C008000, 32'h0, 1);
        run_txn("ertn",    5'b00000, 1, 0, 32'h1C000200, 32'h0, 32'h1C008000, 32'h1C000204, 0);
        run_txn("ertn_ale",5'b10000, 1, 0, 32'h1C000208, 32'h5, 32'h1C008000, 32'h1C000204, 0);
        run_txn("drain10", 5'b01000, 0, 0, 32'h1C000300, 32'h0, 32'h1C008040, 32'h0, 10);

        // flush_ack in IDLE does nothing.
        bus.flush_ack = 1'b1;
        @(negedge clk);
        chk_pulses("idle_ack", 0, 0, 0, 0, 1);
        bus.flush_ack = 1'b0;
        @(negedge clk);
        chk_pulses("idle_ack2", 0, 0, 0, 0, 1);

        // Reset while in DRAIN.
        bus.ex_valid = 1'b1;
        bus.ex_flags = 5'b01000;
        bus.ex_ertn  = 1'b0;
        bus.has_int  = 1'b0;
        bus.ex_pc    = 32'h1C000400;
        @(negedge clk);
        bus.ex_valid = 1'b0;
        @(negedge clk);
        chk_pulses("mid.drain", 0, 0, 1, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_pulses("mid.reset", 0, 0, 0, 0, 1);
        chk("mid.reset.ecode", bus.wb_ecode, 6'h0);
        chk("mid.reset.redirect_pc", bus.redirect_pc, 32'h0);
        @(negedge clk);
        chk_pulses("mid.after", 0, 0, 0, 0, 1);
        run_txn("mid.ale", 5'b10000, 0, 0, 32'h1C000500, 32'h00000003, 32'h1C008000, 32'h0, 0);

        // Back-to-back silent retires.
        for (int i = 0; i < 5; i++)
            run_txn($sformatf("silent%0d", i), 5'b0, 0, 0, 32'h1C000600 + 32'(4 * i),
                    32'h0, 32'h1C008000, 32'h0, 0);

        // Random transactions.
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 3);
            if (r == 0)      rf = 5'b0;
            else if (r == 1) rf = 5'b1 << $urandom_range(0, 4);
            else             rf = 5'($urandom);
            run_txn($sformatf("rnd%0d", i), rf, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 4) == 0, $urandom, $urandom, $urandom, $urandom,
                    $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/exc_commit_ctrl.md
EXC_COMMIT_CTRL -- requirements
Module: exc_commit_ctrl

Interface
REQ-001 The block SHALL use one clock and one reset; reset is synchronous and active-high.
REQ-002 The ports SHALL be as follows (name  direction  width  meaning):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ex_valid  in  1  WB-stage instruction offered for commit.
- ex_flags  in  5  pending exceptions: [0] ADEF, [1] INE, [2] SYS, [3] BRK, [4] ALE.
- ex_ertn  in  1  offered instruction is ertn.
- ex_pc  in  32  PC of offered instruction.
- ex_vaddr  in  32  memory address of offered instruction.
- has_int  in  1  interrupt pending, from the CSR file.
- ex_entry  in  32  exception entry address, from the CSR file.
- ertn_pc  in  32  exception return address, from the CSR file.
- flush_ack  in  1  pipeline reports that the front stages have been cleared.
- ex_ready  out  1  offered instruction accepted this cycle.
- wb_ex  out  1  exception commit pulse to the CSR file.
- wb_ecode  out  6  exception primary code.
- wb_esubcode  out  9  exception subcode.
- wb_pc  out  32  faulting PC.
- wb_vaddr  out  32  faulting address.
- ertn_flush  out  1  ertn commit pulse to the CSR file.
- flush_req  out  1  request to flush the pipeline.
- redirect_valid  out  1  fetch redirect pulse.
- redirect_pc  out  32  fetch redirect target.

Function
REQ-003 The state machine SHALL have four states: IDLE, COMMIT, DRAIN and REDIR.
REQ-004 ex_ready SHALL equal (state==IDLE); a transfer occurs when ex_valid && ex_ready.
REQ-005 On a transfer, the event SHALL be selected by fixed priority: has_int > ADEF > INE > SYS > BRK > ALE > ex_ertn.
REQ-006 Event encodings SHALL be, as ecode/esubcode: INT 0x00/0; ADEF 0x08/0; INE 0x0D/0; SYS 0x0B/0; BRK 0x0C/0; ALE 0x09/0.
REQ-007 On a transfer with an exception selected, the block SHALL register ecode, esubcode, ex_pc and ex_vaddr, and SHALL go IDLE->COMMIT.
REQ-008 On a transfer with only ex_ertn selected, the block SHALL latch kind=ERTN and SHALL go IDLE->COMMIT.
REQ-009 On a transfer with no event (no flags, has_int=0, ex_ertn=0), the instruction SHALL retire silently and the state SHALL remain IDLE.
REQ-010 In COMMIT, for exactly one cycle, the block SHALL assert wb_ex (exception) or ertn_flush (ertn), never both, with wb_ecode, wb_esubcode, wb_pc and wb_vaddr driven from the registered values; the next state SHALL be DRAIN.
REQ-011 wb_ecode, wb_esubcode, wb_pc and wb_vaddr SHALL hold their registered values outside COMMIT; they are don't-care to the consumer.
REQ-012 In DRAIN, flush_req SHALL be 1; flush_ack=1 SHALL move DRAIN->REDIR, and flush_ack=0 SHALL keep the state in DRAIN indefinitely.
REQ-013 flush_ack SHALL be ignored in IDLE, COMMIT and REDIR.
REQ-014 In REDIR, redirect_valid SHALL be 1 for one cycle, and the next state SHALL be IDLE.
REQ-015 In REDIR, redirect_pc SHALL be sampled combinationally: ex_entry when kind=EXC, ertn_pc when kind=ERTN. Sampling after COMMIT guarantees that CSR updates are visible.
REQ-016 Minimum latency SHALL be: transfer at cycle N; wb_ex/ertn_flush at N+1; flush_req from N+2; with flush_ack at N+2, redirect_valid at N+3; ex_ready high again at N+4.
REQ-017 ex_valid while not IDLE SHALL be ignored (ex_ready=0); the requester holds its inputs stable.
REQ-018 has_int SHALL be sampled only at a transfer; has_int toggling in other states SHALL have no effect.
REQ-019 wb_ex, ertn_flush, flush_req and redirect_valid SHALL be mutually exclusive in every cycle.
REQ-020 The block SHALL keep an internal 16-bit saturating DRAIN-cycle counter that clears on entry to DRAIN and provides no output; it exists for assertion use only.

Reset
REQ-021 While rst=1, state SHALL be IDLE, and wb_ex, ertn_flush, flush_req and redirect_valid SHALL be 0.
REQ-022 While rst=1, all registered ecode, esubcode, pc, vaddr and kind fields SHALL be 0, and wb_ecode, wb_esubcode, wb_pc, wb_vaddr and redirect_pc SHALL read 0.
REQ-023 ex_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-024 Reset asserted in any state, including mid-DRAIN, SHALL abort the operation with no further pulses.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- SYS: ex_valid=1, ex_flags=5'b00100, ex_pc=0x1C000100, has_int=0, ex_entry=0x1C008000, flush_ack tied 1 -> wb_ex pulse at N+1 with ecode 0x0B and wb_pc=0x1C000100; redirect_valid at N+3 with redirect_pc=0x1C008000.
- Priority: ex_flags=5'b10011 with has_int=1 -> ecode 0x00. Same flags with has_int=0 -> ecode 0x08, esubcode 0.
- ertn: ex_ertn=1, ex_flags=0, ertn_pc=0x1C000204 -> ertn_flush pulse with wb_ex=0; redirect_pc=0x1C000204. ex_ertn=1 with ex_flags[4]=1 -> ecode 0x09 and no ertn_flush.
- Drain hold: flush_ack held 0 for 10 cycles after COMMIT -> flush_req stays 1 for 10 cycles, ex_ready stays 0, and a flush_ack pulse during IDLE has no effect.
- Mid-operation reset: rst=1 for 1 cycle while in DRAIN -> next cycle all pulses 0, ex_ready=1, and a new ALE transfer (ex_vaddr=0x00000003) completes with ecode 0x09 and wb_vaddr=0x00000003.
- Silent retire: back-to-back ex_valid with no events for 5 cycles -> ex_ready=1 every cycle and no pulses.
